// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg
//   Shared definitions for the cascaded modulo-M counter chain.
//   - DEFAULT_MOD : default per-stage modulus
//   - dir_e       : encoding of the 'up' direction input
//   - digit_width : bits needed to hold one stage value 0..m-1
package mod_counter_pkg;

    localparam int DEFAULT_MOD = 10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Never returns 0, so a degenerate modulus still yields a legal vector
    // width and the elaboration check can report the real problem.
    function automatic int digit_width(input int m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mod_counter_stage.sv
// mod_counter_stage
//   One modulo-M digit of the counter chain.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     step        advance this digit by one in direction 'up'
//     up          1 = increment, 0 = decrement
//     clr         synchronous clear (highest priority)
//     load        synchronous load of ld_digit (clamped to M-1)
//     ld_digit    load value for this digit
//     digit       current digit value, 0..M-1
//     term        terminal flag: digit at M-1 (up) or 0 (down)
module mod_counter_stage
    import mod_counter_pkg::*;
#(
    parameter  int M = DEFAULT_MOD,
    localparam int W = digit_width(M)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] ld_digit,
    output logic [W-1:0] digit,
    output logic         term
);

    localparam logic [W-1:0] MAX = W'(M - 1);

    dir_e dir;
    assign dir = dir_e'(up);

    always_comb begin
        term = (dir == DIR_UP) ? (digit == MAX) : (digit == '0);
    end

    // NOTE: state registers use non-blocking assignment so every stage samples
    // the pre-edge values of its neighbours; blocking here would let a stage
    // see a digit already updated in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (load) begin
            // Clamping keeps values >= M unreachable when M is not a power of two.
            digit <= (ld_digit > MAX) ? MAX : ld_digit;
        end else if (step) begin
            if (dir == DIR_UP) begin
                digit <= term ? '0 : digit + W'(1);
            end else begin
                digit <= term ? MAX : digit - W'(1);
            end
        end
    end

endmodule

// File: rtl/mod_counter_chain.sv
// mod_counter_chain
//   N cascaded modulo-M digits forming a multi-digit up/down counter
//   (M=10 gives a BCD counter). All digits update on the same edge; the
//   carry/borrow is a combinational AND chain of the stage terminals.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     en          count enable, one step per cycle
//     up          1 = increment, 0 = decrement
//     clr         synchronous clear of all digits and ovf (beats load, en)
//     load        synchronous parallel load of ld_val (beats en)
//     ld_val      load value, digit i at [i*W +: W], digit 0 least significant
//     cnt         current count, same packing as ld_val
//     co          combinational chain terminal, masked by clr/load
//     ovf         sticky flag, set on an edge where co=1, cleared by clr
//   Build option:
//     MOD_COUNTER_CHAIN_SAT_EN  saturate at the terminal value instead of wrapping
module mod_counter_chain
    import mod_counter_pkg::*;
#(
    parameter  int M = DEFAULT_MOD,
    parameter  int N = 4,
    localparam int W = digit_width(M)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           up,
    input  logic           clr,
    input  logic           load,
    input  logic [N*W-1:0] ld_val,
    output logic [N*W-1:0] cnt,
    output logic           co,
    output logic           ovf
);

    if (M < 2) begin : g_bad_m
        $error("mod_counter_chain: M must be >= 2");
    end
    if (N < 1) begin : g_bad_n
        $error("mod_counter_chain: N must be >= 1");
    end

    logic [N-1:0] term;
    logic [N-1:0] step;
    logic [N-1:0] step_eff;
    logic         co_raw;

    // The running AND is kept in a local variable rather than indexing step
    // against itself, so the chain is a clean feed-forward path.
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    always_comb begin
        logic run;
        step   = '0;
        co_raw = 1'b0;
        run    = en;
        for (int i = 0; i < N; i++) begin
            step[i] = run;
            run     = run & term[i];
        end
        co_raw = run;
    end

`ifdef MOD_COUNTER_CHAIN_SAT_EN
    // At the terminal value the whole chain freezes instead of wrapping.
    assign step_eff = co_raw ? '0 : step;
`else
    assign step_eff = step;
`endif

    assign co = co_raw & ~clr & ~load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (co) begin
            ovf <= 1'b1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_stage
        mod_counter_stage #(
            .M (M)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (step_eff[i]),
            .up       (up),
            .clr      (clr),
            .load     (load),
            .ld_digit (ld_val[i*W +: W]),
            .digit    (cnt[i*W +: W]),
            .term     (term[i])
        );
    end

endmodule

// File: tb/tb_mod_counter_chain.sv
// tb_mod_counter_chain
//   Directed bench for mod_counter_chain. DUT A: M=10, N=3 (BCD, values
//   written as 12'hDDD). DUT B: M=7, N=2 for the non-power-of-two sweep.
//   Expected count/ovf values for DUT A go through a scoreboard queue.
module tb_mod_counter_chain;

`ifdef MOD_COUNTER_CHAIN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        en_a = 1'b0, up_a = 1'b1, clr_a = 1'b0, load_a = 1'b0;
    logic [11:0] ld_a = '0;
    logic [11:0] cnt_a;
    logic        co_a, ovf_a;

    logic        en_b = 1'b0, up_b = 1'b1, clr_b = 1'b0, load_b = 1'b0;
    logic [5:0]  ld_b = '0;
    logic [5:0]  cnt_b;
    logic        co_b, ovf_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_counter_chain #(.M(10), .N(3)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en_a),
        .up     (up_a),
        .clr    (clr_a),
        .load   (load_a),
        .ld_val (ld_a),
        .cnt    (cnt_a),
        .co     (co_a),
        .ovf    (ovf_a)
    );

    mod_counter_chain #(.M(7), .N(2)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en_b),
        .up     (up_b),
        .clr    (clr_b),
        .load   (load_b),
        .ld_val (ld_b),
        .cnt    (cnt_b),
        .co     (co_b),
        .ovf    (ovf_b)
    );

    typedef struct {
        string       tag;
        logic [11:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic e, input logic u, input logic c,
                           input logic l, input logic [11:0] v);
        en_a = e; up_a = u; clr_a = c; load_a = l; ld_a = v;
    endtask

    // Push the expectation with the stimulus, clock once, pop and compare.
    task automatic step_a(input string tag, input logic [11:0] c, input logic o);
        exp_t e;
        sb.push_back('{tag, c, o});
        tick();
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_cnt"}, 32'(cnt_a), 32'(e.cnt));
            check({e.tag, "_ovf"}, 32'(ovf_a), 32'(e.ovf));
        end
    endtask

    function automatic logic [5:0] enc_b(input int v);
        return {3'(v / 7), 3'(v % 7)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        int co_count;
        int distinct;
        int max_d;
        bit seen [49];

        // Reset state, with en=1/up=1 so co is exercised from the reset value.
        tick();
        tick();
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        #1;
        check("reset_cnt", 32'(cnt_a), 32'h000);
        check("reset_ovf", 32'(ovf_a), 32'd0);
        check("reset_co",  32'(co_a),  32'd0);
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        rst_n = 1'b1;
        tick();

        // Count to 123, then clear.
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 12'h120); step_a("load120", 12'h120, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        step_a("up121", 12'h121, 1'b0);
        step_a("up122", 12'h122, 1'b0);
        step_a("up123", 12'h123, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1, 1'b0, 12'h000); step_a("clr", 12'h000, 1'b0);

        // Up cascade 099 -> 100.
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 12'h099); step_a("load099", 12'h099, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        #1 check("co_099", 32'(co_a), 32'd0);
        step_a("up100", 12'h100, 1'b0);

        // Up wrap from 999.
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 12'h999); step_a("load999", 12'h999, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        #1 check("co_999", 32'(co_a), 32'd1);
        step_a("wrap_up", SAT ? 12'h999 : 12'h000, 1'b1);
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 12'h000); step_a("clr_ovf", 12'h000, 1'b0);

        // Down cascade 100 -> 099, then borrow wrap from 000.
        drive_a(1'b0, 1'b0, 1'b0, 1'b1, 12'h100); step_a("load100", 12'h100, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 12'h000); step_a("dn099", 12'h099, 1'b0);
        drive_a(1'b0, 1'b0, 1'b0, 1'b1, 12'h000); step_a("load000", 12'h000, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        #1 check("co_000", 32'(co_a), 32'd1);
        step_a("wrap_dn", SAT ? 12'h000 : 12'h999, 1'b1);

        // Load keeps ovf; load with en=1 at 999 masks co, clamps F to 9, no step.
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 12'h999); step_a("load_keep_ovf", 12'h999, 1'b1);
        drive_a(1'b1, 1'b1, 1'b0, 1'b1, 12'h2F7);
        #1 check("co_masked_load", 32'(co_a), 32'd0);
        step_a("load_clamp", 12'h297, 1'b1);

        // clr beats load.
        drive_a(1'b1, 1'b1, 1'b1, 1'b1, 12'h555); step_a("clr_load", 12'h000, 1'b0);

        // Enable gating at 456.
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 12'h456); step_a("load456", 12'h456, 1'b0);
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 5; i++) begin
            #1 check("co_hold", 32'(co_a), 32'd0);
            step_a("hold456", 12'h456, 1'b0);
        end

        // Direction change mid-run at 450.
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 12'h450); step_a("load450", 12'h450, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        step_a("up451", 12'h451, 1'b0);
        step_a("up452", 12'h452, 1'b0);
        step_a("up453", 12'h453, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        step_a("dn452", 12'h452, 1'b0);
        step_a("dn451", 12'h451, 1'b0);
        step_a("dn450", 12'h450, 1'b0);

        // Async reset between edges at 777 with ovf set.
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 12'h999); step_a("load999b", 12'h999, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 12'h000); step_a("wrap_up2", SAT ? 12'h999 : 12'h000, 1'b1);
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 12'h777); step_a("load777", 12'h777, 1'b1);
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        #3 rst_n = 1'b0;
        #1;
        check("async_cnt", 32'(cnt_a), 32'h000);
        check("async_ovf", 32'(ovf_a), 32'd0);
        tick();
        rst_n = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0, 1'b0, 12'h000); step_a("resume001", 12'h001, 1'b0);

        // M=7, N=2 full up sweep.
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        check("b_start", 32'(cnt_b), 32'd0);
        v        = 0;
        co_count = 0;
        max_d    = 0;
        foreach (seen[k]) seen[k] = 1'b0;
        seen[0] = 1'b1;
        en_b = 1'b1;
        up_b = 1'b1;
        for (int s = 0; s < 49; s++) begin
            #1;
            if (co_b) co_count++;
            check("b_co", 32'(co_b), 32'(v == 48));
            v = (v == 48) ? (SAT ? 48 : 0) : v + 1;
            tick();
            check("b_cnt", 32'(cnt_b), 32'(enc_b(v)));
            if (int'(cnt_b[2:0]) > max_d) max_d = int'(cnt_b[2:0]);
            if (int'(cnt_b[5:3]) > max_d) max_d = int'(cnt_b[5:3]);
            if (cnt_b[2:0] <= 3'd6 && cnt_b[5:3] <= 3'd6)
                seen[int'(cnt_b[5:3]) * 7 + int'(cnt_b[2:0])] = 1'b1;
        end
        en_b = 1'b0;
        distinct = 0;
        foreach (seen[k]) if (seen[k]) distinct++;
        check("b_co_count", 32'(co_count), 32'd1);
        check("b_distinct", 32'(distinct), 32'd49);
        check("b_max_digit", 32'(max_d), 32'd6);
        check("b_ovf", 32'(ovf_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
